// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store engine: size codes,
// FSM state encoding, byte-strobe constants and the alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // size_in bit selecting zero-extension on loads
  localparam int unsigned UNS_BIT = 2;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE    = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Size code 2'b11 is handled as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication/strobes and
// load extraction with sign or zero extension.
module mem_lane_align import mem_pkg::*; (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = STRB_WORD;
    case (st_size)
      SZ_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = STRB_BYTE << st_lane;
      end
      SZ_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = st_lane[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte  = ld_rdata[{ld_lane, 3'b000} +: 8];
    ld_half  = ld_rdata[{ld_lane[1], 4'b0000} +: 16];
    ld_value = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_value = ld_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = ld_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack bus transaction per access,
// pipeline stall while outstanding, timeout abort with a bus_err pulse.
module mem_access_unit import mem_pkg::*; #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mio_in,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  size_in,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        exc_misalign,
  output logic        bus_err
);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  ld_lane;
  logic        flush_q;
  logic        misaligned;
  logic        accept;
  logic        kill;
  logic        expired;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_value;

  mem_lane_align u_align (
    .st_size  (size_in[1:0]),
    .st_lane  (addr_in[1:0]),
    .st_data  (wdata_in),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_size  (ld_size),
    .ld_uns   (ld_uns),
    .ld_lane  (ld_lane),
    .ld_rdata (bus_rdata),
    .ld_value (ld_value)
  );

  always_comb begin
    misaligned   = is_misaligned(size_in[1:0], addr_in[1:0]);
    exc_misalign = mio_in && misaligned;
    accept       = (state == ST_IDLE) && mio_in && !misaligned && !flush;
    // Accept cycle stalls combinationally so the EX/MEM latch holds at once.
    stall        = accept || (state == ST_BUSY);
    kill         = flush || flush_q;
    expired      = (cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= STRB_NONE;
      load_data <= '0;
      bus_err   <= 1'b0;
      ld_size   <= SZ_WORD;
      ld_uns    <= 1'b0;
      ld_lane   <= '0;
      flush_q   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          flush_q <= 1'b0;
          cnt     <= '0;
          if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= we_in;
            bus_addr  <= {addr_in[31:2], 2'b00};
            bus_wdata <= we_in ? st_wdata : '0;
            bus_wstrb <= we_in ? st_wstrb : STRB_NONE;
            ld_size   <= size_in[1:0];
            ld_uns    <= size_in[UNS_BIT];
            ld_lane   <= addr_in[1:0];
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) flush_q <= 1'b1;
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we && !kill) load_data <= ld_value;
            state <= ST_DONE;
          end else if (expired) begin
            bus_req <= 1'b0;
            if (!kill) begin
              bus_err <= 1'b1;
              if (!bus_we) load_data <= '0;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand sequences for
// flush/reset/misalignment, then random accesses against a reference model.
module tb_mem_access_unit;

  localparam int TMO = 4;
  localparam int NO_ACK = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mio_in = 1'b0;
  logic        we_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [2:0]  size_in = '0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] load_data;
  logic        stall;
  logic        exc_misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mio_in       (mio_in),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .size_in      (size_in),
    .flush        (flush),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .load_data    (load_data),
    .stall        (stall),
    .exc_misalign (exc_misalign),
    .bus_err      (bus_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic [31:0] rd;
    int          delay;
    int          flush_at;
    logic [31:0] exp_ld;
    logic        exp_err;
    logic [31:0] exp_wd;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t tbl[13];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: extraction by shifting and masking the read word.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [2:0] sz);
    logic [31:0] v;
    case (sz[1:0])
      2'b00: begin
        v = (rd >> (8 * int'(lane))) & 32'h0000_00FF;
        if (!sz[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (rd >> (16 * (int'(lane) / 2))) & 32'h0000_FFFF;
        if (!sz[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return {24'h0, wd[7:0]} * 32'h0101_0101;
      2'b01:   return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] lane, input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return 4'(1 << int'(lane));
      2'b01:   return (lane >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [1:0] lane, input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 1'b0;
    if (sz[1:0] == 2'b01) return (int'(lane) % 2) != 0;
    return lane != 2'b00;
  endfunction

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_access(input vec_t v);
    int busy_n;
    busy_n = (v.delay < TMO) ? v.delay + 1 : TMO;
    mio_in = 1'b1; we_in = v.we; addr_in = v.addr; wdata_in = v.wd; size_in = v.sz;
    flush = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk1("accept_stall", stall, 1'b1);
    chk1("accept_req", bus_req, 1'b0);
    chk1("accept_misalign", exc_misalign, 1'b0);
    for (int k = 0; k < busy_n; k++) begin
      @(posedge clk); #1;
      bus_ack = (k == v.delay);
      bus_rdata = (k == v.delay) ? v.rd : $urandom;
      flush = (k == v.flush_at);
      @(negedge clk);
      chk1("busy_req", bus_req, 1'b1);
      chk1("busy_stall", stall, 1'b1);
      chk1("busy_err", bus_err, 1'b0);
      if (k == 0) begin
        chk32("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk1("bus_we", bus_we, v.we);
        chk32("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, v.we ? v.exp_strb : 4'b0000});
        if (v.we) chk32("bus_wdata", bus_wdata, v.exp_wd);
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk1("done_req", bus_req, 1'b0);
    chk1("done_stall", stall, 1'b0);
    chk1("done_err", bus_err, v.exp_err);
    chk32("done_load", load_data, v.exp_ld);
    @(posedge clk); #1;
    mio_in = 1'b0;
    @(negedge clk);
    chk1("idle_req", bus_req, 1'b0);
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_err", bus_err, 1'b0);
    chk32("idle_load", load_data, v.exp_ld);
    @(posedge clk); #1;
  endtask

  task automatic run_misaligned(input logic we, input logic [31:0] addr, input logic [2:0] sz);
    mio_in = 1'b1; we_in = we; addr_in = addr; size_in = sz; flush = 1'b0;
    @(negedge clk);
    chk1("mis_exc", exc_misalign, 1'b1);
    chk1("mis_stall", stall, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("mis_req", bus_req, 1'b0);
    chk32("mis_load", load_data, exp_ld);
    mio_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t rv;
    logic [1:0] lane;
    logic flushed;

    tbl[0]  = '{1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 0, -1, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0};
    tbl[1]  = '{1'b0, 32'h103, 32'h0, 3'b000, 32'h80FF0000, 0, -1, 32'hFFFFFF80, 1'b0, 32'h0, 4'h0};
    tbl[2]  = '{1'b0, 32'h103, 32'h0, 3'b100, 32'h80FF0000, 1, -1, 32'h00000080, 1'b0, 32'h0, 4'h0};
    tbl[3]  = '{1'b1, 32'h206, 32'h1234ABCD, 3'b001, 32'h0, 0, -1, 32'h00000080, 1'b0, 32'hABCDABCD, 4'b1100};
    tbl[4]  = '{1'b0, 32'h202, 32'h0, 3'b001, 32'h80017FFF, 2, -1, 32'hFFFF8001, 1'b0, 32'h0, 4'h0};
    tbl[5]  = '{1'b0, 32'h200, 32'h0, 3'b101, 32'h8001F00D, 0, -1, 32'h0000F00D, 1'b0, 32'h0, 4'h0};
    tbl[6]  = '{1'b1, 32'h101, 32'h000000AA, 3'b000, 32'h0, 1, -1, 32'h0000F00D, 1'b0, 32'hAAAAAAAA, 4'b0010};
    tbl[7]  = '{1'b1, 32'h300, 32'h01234567, 3'b011, 32'h0, 0, -1, 32'h0000F00D, 1'b0, 32'h01234567, 4'b1111};
    tbl[8]  = '{1'b0, 32'h102, 32'h0, 3'b100, 32'h00AB0000, 1, -1, 32'h000000AB, 1'b0, 32'h0, 4'h0};
    tbl[9]  = '{1'b0, 32'h400, 32'h0, 3'b010, 32'h0, NO_ACK, -1, 32'h0, 1'b1, 32'h0, 4'h0};
    tbl[10] = '{1'b0, 32'h404, 32'h0, 3'b010, 32'h13579BDF, TMO - 1, -1, 32'h13579BDF, 1'b0, 32'h0, 4'h0};
    tbl[11] = '{1'b0, 32'h104, 32'h0, 3'b010, 32'h00000055, 2, 0, 32'h13579BDF, 1'b0, 32'h0, 4'h0};
    tbl[12] = '{1'b0, 32'h108, 32'h0, 3'b010, 32'h0, NO_ACK, 1, 32'h13579BDF, 1'b0, 32'h0, 4'h0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_we", bus_we, 1'b0);
    chk32("rst_addr", bus_addr, 32'h0);
    chk32("rst_wdata", bus_wdata, 32'h0);
    chk32("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk32("rst_load", load_data, 32'h0);
    chk1("rst_err", bus_err, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_access(tbl[i]);
      exp_ld = tbl[i].exp_ld;
    end

    run_misaligned(1'b0, 32'h102, 3'b010);
    run_misaligned(1'b1, 32'h301, 3'b001);

    // Flush while idle suppresses the access entirely.
    mio_in = 1'b1; we_in = 1'b0; addr_in = 32'h500; size_in = 3'b010; flush = 1'b1;
    @(negedge clk);
    chk1("iflush_stall", stall, 1'b0);
    @(posedge clk); #1;
    mio_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk1("iflush_req", bus_req, 1'b0);
    @(posedge clk); #1;

    // Reset while a request is outstanding abandons it.
    mio_in = 1'b1; we_in = 1'b0; addr_in = 32'h600; size_in = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rbusy_req", bus_req, 1'b1);
    rst = 1'b1; mio_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rbusy_req_drop", bus_req, 1'b0);
    chk1("rbusy_stall", stall, 1'b0);
    chk32("rbusy_load", load_data, 32'h0);
    rst = 1'b0;
    exp_ld = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rbusy_idle_req", bus_req, 1'b0);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      rv.we   = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      rv.sz   = 3'($urandom_range(0, 7));
      rv.wd   = $urandom;
      rv.rd   = $urandom;
      lane    = rv.addr[1:0];
      if (model_misaligned(lane, rv.sz)) begin
        run_misaligned(rv.we, rv.addr, rv.sz);
        continue;
      end
      rv.delay    = rv.we ? $urandom_range(0, TMO - 2) : $urandom_range(0, TMO + 1);
      rv.flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : -1;
      flushed = (rv.flush_at >= 0) && (rv.flush_at <= rv.delay) && (rv.flush_at < TMO);
      rv.exp_wd   = model_wdata(rv.wd, rv.sz);
      rv.exp_strb = model_strb(lane, rv.sz);
      rv.exp_err  = (rv.delay >= TMO) && !flushed;
      rv.exp_ld   = exp_ld;
      if (!rv.we && !flushed) rv.exp_ld = (rv.delay >= TMO) ? 32'h0 : model_load(rv.rd, lane, rv.sz);
      run_access(rv);
      exp_ld = rv.exp_ld;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
